guess_game_controller: RTL and testbench
========================================

GUESS_GAME_CONTROLLER -- requirements
Module: guess_game_controller

Interface
REQ-001 Parameter: MAX_GUESSES, 4'd7, attempts per round; legal range 1..15.
REQ-002 Parameter: FEEDBACK_CYCLES, 16'd50000, clocks the FEEDBACK state is held; legal range 1..65535.
REQ-003 Port: clk  input  1  the single clock; all registers update on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  level from debounced button; acted on at its rising edge only.
REQ-006 Port: submit  input  1  level from debounced button; acted on at its rising edge only.
REQ-007 Port: switches  input  4  the player's guess value.
REQ-008 Port: state  output  3  game state: 000 WAIT, 001 GUESSING, 010 FEEDBACK, 011 WIN, 100 LOSE.
REQ-009 Port: guess  output  4  feedback code: 0000 too low, 0001 too high, 0010 correct, 1111 none.
REQ-010 Port: remaining_guesses  output  4  attempts left in the current round.
REQ-011 Port: secret_out  output  4  the secret value in WIN/LOSE; 0 in all other states.

Function
REQ-012 All outputs shall be registered; no combinational path from any input to any output.
REQ-013 Edge detect: start_prev and submit_prev are registered every cycle; rise = input high AND prev low.
REQ-014 Seed: 4-bit seed counter increments every cycle when not in reset and wraps 15->0.
REQ-015 WAIT: a start rise captures secret <= seed, sets remaining_guesses <= MAX_GUESSES, guess <= 1111, and moves to GUESSING on the next edge.
REQ-016 WAIT: submit shall be ignored.
REQ-017 GUESSING: a submit rise compares switches (unsigned) to secret in the same cycle.
REQ-018 GUESSING, equal: move to WIN; guess <= 0010; remaining_guesses unchanged.
REQ-019 GUESSING, switches < secret: guess <= 0000; remaining_guesses decrements by 1.
REQ-020 GUESSING, switches > secret: guess <= 0001; remaining_guesses decrements by 1.
REQ-021 GUESSING, miss: if the decremented value is 0, move to LOSE; otherwise move to FEEDBACK and load timer <= FEEDBACK_CYCLES-1.
REQ-022 GUESSING: start shall be ignored.
REQ-023 FEEDBACK: the timer decrements each cycle; in the cycle the timer reads 0, move to GUESSING.
REQ-024 FEEDBACK: guess holds its code until the next submit evaluation; submit and start are ignored.
REQ-025 FEEDBACK duration: exactly FEEDBACK_CYCLES clocks, with state == 010.
REQ-026 WIN/LOSE: hold state and secret_out = secret until a start rise, which moves to WAIT with guess <= 1111 and remaining_guesses <= 0.
REQ-027 WIN/LOSE: submit shall be ignored.
REQ-028 Simultaneous start and submit rises: only the one legal in the current state acts.
REQ-029 Held inputs: a held start or submit acts once; it shall not act again until it falls and rises.
REQ-030 Unreachable state encodings (101-111) shall move to WAIT on the next edge.
REQ-031 remaining_guesses shall never decrement below 0 or wrap.

Reset
REQ-032 With reset high at a clk edge, the next values shall be: state = 000, guess = 1111, remaining_guesses = 0, secret_out = 0, secret = 0, seed = 0, timer = 0, start_prev = 0, submit_prev = 0.
REQ-033 Reset shall take priority over all inputs and abort any round in progress, including mid-FEEDBACK.
REQ-034 start held high through reset release shall register one rise on the first edge after release.

Verification
REQ-035 Reset, then start rise when seed = 5 -> secret = 5; next edge state = 001, remaining_guesses = 7, guess = 1111.
REQ-036 Secret 5, submit with switches = 3 -> state = 010, guess = 0000, remaining_guesses = 6; after exactly FEEDBACK_CYCLES clocks (bench uses 4) -> state = 001.
REQ-037 Secret 5, submit with switches = 9 then switches = 5 -> first response guess = 0001; second response state = 011, guess = 0010, secret_out = 5; a later start rise -> state = 000.
REQ-038 MAX_GUESSES = 2, secret 5, two wrong submits -> remaining_guesses 1 then 0; state goes to 100 directly, with no FEEDBACK after the last miss; secret_out = 5.
REQ-039 submit held high for 10 cycles in GUESSING -> exactly one decrement; submit pulsed during FEEDBACK -> no change.
REQ-040 reset asserted mid-FEEDBACK -> next edge state = 000, guess = 1111, remaining_guesses = 0; start and submit both pulsed in WAIT -> only start acts.

Source files
------------

// File: rtl/guess_game_controller.sv
// Number-guessing game controller.
// The player presses start to draw a secret from a free-running 4-bit seed,
// then submits guesses on the switches. Each guess gets a too-low, too-high or
// correct code. A miss shows its code for a fixed FEEDBACK period before the
// next guess is accepted. Running out of attempts ends the round in LOSE.
// Every output is a flop, so no input reaches an output combinationally.
module guess_game_controller #(
    parameter logic [3:0]  MAX_GUESSES     = 4'd7,
    parameter logic [15:0] FEEDBACK_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       submit,
    input  logic [3:0] switches,
    output logic [2:0] state,
    output logic [3:0] guess,
    output logic [3:0] remaining_guesses,
    output logic [3:0] secret_out
);

    typedef enum logic [2:0] {
        ST_WAIT     = 3'b000,
        ST_GUESSING = 3'b001,
        ST_FEEDBACK = 3'b010,
        ST_WIN      = 3'b011,
        ST_LOSE     = 3'b100
    } state_t;

    localparam logic [3:0] CODE_LOW     = 4'b0000;
    localparam logic [3:0] CODE_HIGH    = 4'b0001;
    localparam logic [3:0] CODE_CORRECT = 4'b0010;
    localparam logic [3:0] CODE_NONE    = 4'b1111;

    state_t      state_q, state_d;
    logic [3:0]  guess_q, guess_d;
    logic [3:0]  remaining_q, remaining_d;
    logic [3:0]  secret_out_q, secret_out_d;
    logic [3:0]  secret_q, secret_d;
    logic [3:0]  seed_q, seed_d;
    logic [15:0] timer_q, timer_d;
    logic        start_prev_q, submit_prev_q;

    logic        start_rise;
    logic        submit_rise;
    logic [3:0]  remaining_dec;

    // Buttons only act on a low-to-high transition, so a held button acts once.
    assign start_rise  = start & ~start_prev_q;
    assign submit_rise = submit & ~submit_prev_q;

    // Saturating decrement; GUESSING is never entered with zero attempts, but
    // the counter still must not wrap if it ever were.
    assign remaining_dec = (remaining_q != 4'd0) ? (remaining_q - 4'd1) : 4'd0;

    // Next-state and next-output logic for the game FSM.
    always_comb begin
        state_d     = state_q;
        guess_d     = guess_q;
        remaining_d = remaining_q;
        secret_d    = secret_q;
        timer_d     = timer_q;
        seed_d      = seed_q + 4'd1;

        case (state_q)
            ST_WAIT: begin
                if (start_rise) begin
                    secret_d    = seed_q;
                    remaining_d = MAX_GUESSES;
                    guess_d     = CODE_NONE;
                    state_d     = ST_GUESSING;
                end
            end
            ST_GUESSING: begin
                if (submit_rise) begin
                    if (switches == secret_q) begin
                        guess_d = CODE_CORRECT;
                        state_d = ST_WIN;
                    end else begin
                        guess_d     = (switches < secret_q) ? CODE_LOW : CODE_HIGH;
                        remaining_d = remaining_dec;
                        if (remaining_dec == 4'd0) begin
                            state_d = ST_LOSE;
                        end else begin
                            state_d = ST_FEEDBACK;
                            timer_d = FEEDBACK_CYCLES - 16'd1;
                        end
                    end
                end
            end
            ST_FEEDBACK: begin
                // Timer is loaded with N-1 and counts to 0, giving N cycles here.
                if (timer_q == 16'd0) begin
                    state_d = ST_GUESSING;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (start_rise) begin
                    guess_d     = CODE_NONE;
                    remaining_d = 4'd0;
                    state_d     = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        // The secret is revealed only once the round has ended.
        secret_out_d = ((state_d == ST_WIN) || (state_d == ST_LOSE)) ? secret_d : 4'd0;
    end

    // State, datapath and edge-detect registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_WAIT;
            guess_q       <= CODE_NONE;
            remaining_q   <= 4'd0;
            secret_out_q  <= 4'd0;
            secret_q      <= 4'd0;
            seed_q        <= 4'd0;
            timer_q       <= 16'd0;
            start_prev_q  <= 1'b0;
            submit_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            guess_q       <= guess_d;
            remaining_q   <= remaining_d;
            secret_out_q  <= secret_out_d;
            secret_q      <= secret_d;
            seed_q        <= seed_d;
            timer_q       <= timer_d;
            start_prev_q  <= start;
            submit_prev_q <= submit;
        end
    end

    assign state             = state_q;
    assign guess             = guess_q;
    assign remaining_guesses = remaining_q;
    assign secret_out        = secret_out_q;

endmodule

// File: tb/tb_guess_game_controller.sv
// Bench for guess_game_controller: a vector table for the main round, then
// hand-written sequences for held buttons, mid-FEEDBACK reset, simultaneous
// buttons, start held through reset, and the LOSE path on a 2-guess instance.
module tb_guess_game_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic [3:0] switches = 4'd0;

    logic [2:0] state_a, state_b;
    logic [3:0] guess_a, guess_b;
    logic [3:0] rem_a, rem_b;
    logic [3:0] sec_a, sec_b;

    guess_game_controller #(
        .MAX_GUESSES(4'd7),
        .FEEDBACK_CYCLES(16'd4)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start), .submit(submit),
        .switches(switches), .state(state_a), .guess(guess_a),
        .remaining_guesses(rem_a), .secret_out(sec_a)
    );

    guess_game_controller #(
        .MAX_GUESSES(4'd2),
        .FEEDBACK_CYCLES(16'd4)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start), .submit(submit),
        .switches(switches), .state(state_b), .guess(guess_b),
        .remaining_guesses(rem_b), .secret_out(sec_b)
    );

    always #5 clk = ~clk;

    // Reference model of the free-running seed counter.
    logic [3:0] tb_seed;
    always @(posedge clk) begin
        if (reset) tb_seed <= 4'd0;
        else       tb_seed <= tb_seed + 4'd1;
    end

    typedef struct {
        logic [2:0] st;
        logic [3:0] gs;
        logic [3:0] rm;
        logic [3:0] so;
    } exp_t;

    typedef struct {
        logic       r;
        logic       s;
        logic       b;
        logic [3:0] w;
        exp_t       e;
    } vec_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    vec_t tbl[24];

    function automatic exp_t ex(input int st, input int gs, input int rm, input int so);
        exp_t e;
        e.st = st[2:0];
        e.gs = gs[3:0];
        e.rm = rm[3:0];
        e.so = so[3:0];
        return e;
    endfunction

    function automatic vec_t mkv(input int r, input int s, input int b, input int w,
                                 input int st, input int gs, input int rm, input int so);
        vec_t v;
        v.r = r[0];
        v.s = s[0];
        v.b = b[0];
        v.w = w[3:0];
        v.e = ex(st, gs, rm, so);
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp_v);
        total++;
        if (got != exp_v) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, exp_v);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, and compare the
    // registered outputs just after the next rising edge.
    task automatic apply(input int r, input int s, input int b, input int w,
                         input exp_t e, input int which, input string nm);
        exp_t p;
        logic [2:0] a_st;
        logic [3:0] a_gs, a_rm, a_so;
        sbq.push_back(e);
        reset    = r[0];
        start    = s[0];
        submit   = b[0];
        switches = w[3:0];
        @(posedge clk);
        #1;
        p = sbq.pop_front();
        if (which == 0) begin
            a_st = state_a; a_gs = guess_a; a_rm = rem_a; a_so = sec_a;
        end else begin
            a_st = state_b; a_gs = guess_b; a_rm = rem_b; a_so = sec_b;
        end
        $display("%s: dut=%0d rst=%0d start=%0d submit=%0d sw=%0d -> state=%0d guess=%0d rem=%0d secret_out=%0d",
                 nm, which, r, s, b, w, a_st, a_gs, a_rm, a_so);
        chk({nm, ".state"}, int'(a_st), int'(p.st));
        chk({nm, ".guess"}, int'(a_gs), int'(p.gs));
        chk({nm, ".remaining"}, int'(a_rm), int'(p.rm));
        chk({nm, ".secret_out"}, int'(a_so), int'(p.so));
    endtask

    // Reset, idle until the modelled seed equals target, then press start.
    task automatic start_round(input int target, input int which, input int maxg);
        apply(1, 0, 0, 0, ex(0, 15, 0, 0), which, "rnd_reset");
        for (int k = 0; k < 20 && int'(tb_seed) != target; k++) begin
            apply(0, 0, 0, 0, ex(0, 15, 0, 0), which, "rnd_idle");
        end
        apply(0, 1, 0, 0, ex(1, 15, maxg, 0), which, "rnd_start");
        apply(0, 0, 0, 0, ex(1, 15, maxg, 0), which, "rnd_release");
    endtask

    initial begin
        // Main round on the 7-guess instance: secret drawn at seed 5.
        tbl[0]  = mkv(1, 0, 0, 0, 0, 15, 0, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 0, 15, 0, 0);
        tbl[2]  = mkv(0, 0, 1, 0, 0, 15, 0, 0);   // submit ignored in WAIT
        tbl[3]  = mkv(0, 0, 0, 0, 0, 15, 0, 0);
        tbl[4]  = mkv(0, 0, 0, 0, 0, 15, 0, 0);
        tbl[5]  = mkv(0, 0, 0, 0, 0, 15, 0, 0);
        tbl[6]  = mkv(0, 1, 0, 0, 1, 15, 7, 0);   // start at seed 5
        tbl[7]  = mkv(0, 1, 0, 0, 1, 15, 7, 0);   // held start ignored
        tbl[8]  = mkv(0, 0, 1, 3, 2, 0, 6, 0);    // too low
        tbl[9]  = mkv(0, 0, 1, 3, 2, 0, 6, 0);
        tbl[10] = mkv(0, 0, 0, 3, 2, 0, 6, 0);
        tbl[11] = mkv(0, 0, 1, 3, 2, 0, 6, 0);    // submit during FEEDBACK
        tbl[12] = mkv(0, 0, 0, 3, 1, 0, 6, 0);    // 4 cycles of FEEDBACK done
        tbl[13] = mkv(0, 0, 1, 9, 2, 1, 5, 0);    // too high
        tbl[14] = mkv(0, 0, 1, 9, 2, 1, 5, 0);
        tbl[15] = mkv(0, 0, 1, 9, 2, 1, 5, 0);
        tbl[16] = mkv(0, 0, 1, 9, 2, 1, 5, 0);
        tbl[17] = mkv(0, 0, 1, 9, 1, 1, 5, 0);    // held submit does not re-act
        tbl[18] = mkv(0, 0, 0, 9, 1, 1, 5, 0);
        tbl[19] = mkv(0, 0, 1, 5, 3, 2, 5, 5);    // correct -> WIN
        tbl[20] = mkv(0, 0, 0, 3, 3, 2, 5, 5);
        tbl[21] = mkv(0, 0, 1, 3, 3, 2, 5, 5);    // submit ignored in WIN
        tbl[22] = mkv(0, 1, 0, 3, 0, 15, 0, 0);   // start -> WAIT
        tbl[23] = mkv(0, 0, 0, 3, 0, 15, 0, 0);

        for (int i = 0; i < 24; i++) begin
            apply(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].w, tbl[i].e, 0, $sformatf("vec%0d", i));
        end

        // Submit held 10 cycles in GUESSING, then a pulse during FEEDBACK.
        start_round(5, 0, 7);
        for (int i = 1; i <= 10; i++) begin
            apply(0, 0, 1, 3, ex((i <= 4) ? 2 : 1, 0, 6, 0), 0, "held_submit");
        end
        apply(0, 0, 0, 3, ex(1, 0, 6, 0), 0, "held_release");
        apply(0, 0, 1, 3, ex(2, 0, 5, 0), 0, "miss2");
        apply(0, 0, 0, 3, ex(2, 0, 5, 0), 0, "fb_t2");
        apply(0, 0, 1, 3, ex(2, 0, 5, 0), 0, "fb_pulse");
        apply(0, 1, 0, 3, ex(2, 0, 5, 0), 0, "fb_start_ign");
        apply(0, 0, 0, 3, ex(1, 0, 5, 0), 0, "fb_exit");

        // Reset in the middle of FEEDBACK, then start+submit together in WAIT.
        apply(0, 0, 1, 12, ex(2, 1, 4, 0), 0, "miss3");
        apply(1, 0, 0, 0, ex(0, 15, 0, 0), 0, "reset_mid_fb");
        apply(0, 1, 1, 5, ex(1, 15, 7, 0), 0, "start_and_submit");
        apply(0, 0, 0, 0, ex(1, 15, 7, 0), 0, "both_release");
        apply(0, 0, 1, 0, ex(3, 2, 7, 0), 0, "win_seed0");
        apply(0, 1, 0, 0, ex(0, 15, 0, 0), 0, "win_restart");

        // Start held high through reset release acts once.
        apply(1, 1, 0, 0, ex(0, 15, 0, 0), 0, "reset_start_held");
        apply(0, 1, 0, 0, ex(1, 15, 7, 0), 0, "start_after_release");
        apply(0, 1, 0, 0, ex(1, 15, 7, 0), 0, "start_still_held");
        apply(0, 0, 0, 0, ex(1, 15, 7, 0), 0, "start_dropped");

        // LOSE path on the 2-guess instance, secret drawn at seed 9.
        start_round(9, 1, 2);
        apply(0, 0, 1, 0, ex(2, 0, 1, 0), 1, "lose_miss1");
        apply(0, 0, 0, 0, ex(2, 0, 1, 0), 1, "lose_fb");
        apply(0, 0, 0, 0, ex(2, 0, 1, 0), 1, "lose_fb");
        apply(0, 0, 0, 0, ex(2, 0, 1, 0), 1, "lose_fb");
        apply(0, 0, 0, 0, ex(1, 0, 1, 0), 1, "lose_back");
        apply(0, 0, 1, 15, ex(4, 1, 0, 9), 1, "lose_miss2");
        apply(0, 0, 0, 15, ex(4, 1, 0, 9), 1, "lose_hold");
        apply(0, 0, 1, 15, ex(4, 1, 0, 9), 1, "lose_submit_ign");
        apply(0, 1, 0, 0, ex(0, 15, 0, 0), 1, "lose_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
